// File: rtl/spec_ras.sv
// Return address stack for the branch predictor.
// Circular buffer of DATA_DEPTH entries. tos_q points at the current top
// entry and cnt_q holds the occupancy. A push into a full stack overwrites
// the oldest entry and sets a sticky overflow flag. Checkpoint outputs are
// the pointer and count; restore_i reloads them after a mispredict.
// Per-cycle priority: reset > flush > restore > push/pop.
module spec_ras #(
   parameter int DATA_WIDTH = 64,
   parameter int DATA_DEPTH = 8,
   localparam int PTR_W = $clog2(DATA_DEPTH),
   localparam int CNT_W = $clog2(DATA_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  bp_flush_i,
   input  logic                  ras_push_i,
   input  logic                  ras_pop_i,
   input  logic [DATA_WIDTH-1:0] ras_data_i,
   input  logic                  restore_i,
   input  logic [PTR_W-1:0]      restore_ptr_i,
   input  logic [CNT_W-1:0]      restore_cnt_i,
   output logic [PTR_W-1:0]      ckpt_ptr_o,
   output logic [CNT_W-1:0]      ckpt_cnt_o,
   output logic                  ras_data_vld_o,
   output logic [DATA_WIDTH-1:0] ras_data_o,
   output logic                  ras_full_o,
   output logic                  ras_ovf_o
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DATA_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [PTR_W-1:0]      tos_q, tos_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  mem_we;
   logic [PTR_W-1:0]      mem_waddr;
   logic                  empty;

   assign empty = (cnt_q == '0);

   // Next-state and memory write selection, highest priority request wins.
   always_comb begin
      tos_d     = tos_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      mem_we    = 1'b0;
      mem_waddr = tos_q;
      if (bp_flush_i) begin
         tos_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (restore_i) begin
         tos_d = restore_ptr_i;
         cnt_d = (restore_cnt_i > DEPTH_C) ? DEPTH_C : restore_cnt_i;
      end else if (ras_push_i && ras_pop_i && !empty) begin
         // Return immediately followed by a call: replace the top in place.
         mem_we    = 1'b1;
         mem_waddr = tos_q;
      end else if (ras_push_i) begin
         tos_d     = tos_q + 1'b1;
         mem_we    = 1'b1;
         mem_waddr = tos_q + 1'b1;
         if (cnt_q == DEPTH_C) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (ras_pop_i && !empty) begin
         tos_d = tos_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Pointer, count and sticky overflow registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tos_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         tos_q <= tos_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Entry storage; not reset, but writes are blocked while reset is held.
   always_ff @(posedge clk_i) begin
      if (rst_ni && mem_we) begin
         mem_q[mem_waddr] <= ras_data_i;
      end
   end

   assign ras_data_vld_o = !empty;
   assign ras_full_o     = (cnt_q == DEPTH_C);
   assign ras_data_o     = empty ? '0 : mem_q[tos_q];
   assign ras_ovf_o      = ovf_q;
   assign ckpt_ptr_o     = tos_q;
   assign ckpt_cnt_o     = cnt_q;

endmodule

// File: tb/tb_spec_ras.sv
// Bench for spec_ras at DATA_DEPTH = 4: reference model feeds an
// expectation queue each cycle, DUT outputs are popped and compared after
// the clock edge, plus direct checks of the documented scenario values.
module tb_spec_ras;

   localparam int DW = 32;
   localparam int DD = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          bp_flush_i = 1'b0;
   logic          ras_push_i = 1'b0;
   logic          ras_pop_i = 1'b0;
   logic [DW-1:0] ras_data_i = '0;
   logic          restore_i = 1'b0;
   logic [1:0]    restore_ptr_i = '0;
   logic [2:0]    restore_cnt_i = '0;
   logic [1:0]    ckpt_ptr_o;
   logic [2:0]    ckpt_cnt_o;
   logic          ras_data_vld_o;
   logic [DW-1:0] ras_data_o;
   logic          ras_full_o;
   logic          ras_ovf_o;

   spec_ras #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) u_dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .bp_flush_i     (bp_flush_i),
      .ras_push_i     (ras_push_i),
      .ras_pop_i      (ras_pop_i),
      .ras_data_i     (ras_data_i),
      .restore_i      (restore_i),
      .restore_ptr_i  (restore_ptr_i),
      .restore_cnt_i  (restore_cnt_i),
      .ckpt_ptr_o     (ckpt_ptr_o),
      .ckpt_cnt_o     (ckpt_cnt_o),
      .ras_data_vld_o (ras_data_vld_o),
      .ras_data_o     (ras_data_o),
      .ras_full_o     (ras_full_o),
      .ras_ovf_o      (ras_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string         tag;
      logic [DW-1:0] data;
      logic          vld;
      logic          full;
      logic          ovf;
      logic [1:0]    ptr;
      logic [2:0]    cnt;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] m_mem [DD];
   int            m_tos = 0;
   int            m_cnt = 0;
   bit            m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, queue the expected
   // outputs, then compare the DUT after the edge.
   task automatic step(input string tag, input bit rst, input bit flush,
                       input bit restore, input int rp, input int rc,
                       input bit push, input bit pop, input logic [DW-1:0] d);
      exp_t e;
      exp_t o;
      @(negedge clk_i);
      rst_ni        = rst;
      bp_flush_i    = flush;
      restore_i     = restore;
      restore_ptr_i = 2'(rp);
      restore_cnt_i = 3'(rc);
      ras_push_i    = push;
      ras_pop_i     = pop;
      ras_data_i    = d;
      if (!rst) begin
         m_tos = 0; m_cnt = 0; m_ovf = 1'b0;
      end else if (flush) begin
         m_tos = 0; m_cnt = 0; m_ovf = 1'b0;
      end else if (restore) begin
         m_tos = rp;
         m_cnt = (rc > DD) ? DD : rc;
      end else if (push && pop && m_cnt > 0) begin
         m_mem[m_tos] = d;
      end else if (push) begin
         m_tos = (m_tos + 1) % DD;
         m_mem[m_tos] = d;
         if (m_cnt == DD) m_ovf = 1'b1;
         else m_cnt++;
      end else if (pop && m_cnt > 0) begin
         m_tos = (m_tos + DD - 1) % DD;
         m_cnt--;
      end
      e.tag  = tag;
      e.vld  = (m_cnt != 0);
      e.data = e.vld ? m_mem[m_tos] : '0;
      e.full = (m_cnt == DD);
      e.ovf  = m_ovf;
      e.ptr  = 2'(m_tos);
      e.cnt  = 3'(m_cnt);
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      o = exp_q.pop_front();
      chk({o.tag, ".vld"},  64'(ras_data_vld_o), 64'(o.vld));
      chk({o.tag, ".data"}, 64'(ras_data_o),     64'(o.data));
      chk({o.tag, ".full"}, 64'(ras_full_o),     64'(o.full));
      chk({o.tag, ".ovf"},  64'(ras_ovf_o),      64'(o.ovf));
      chk({o.tag, ".ptr"},  64'(ckpt_ptr_o),     64'(o.ptr));
      chk({o.tag, ".cnt"},  64'(ckpt_cnt_o),     64'(o.cnt));
   endtask

   task automatic push(input string tag, input logic [DW-1:0] d);
      step(tag, 1, 0, 0, 0, 0, 1, 0, d);
   endtask

   task automatic pop(input string tag);
      step(tag, 1, 0, 0, 0, 0, 0, 1, '0);
   endtask

   task automatic flush(input string tag);
      step(tag, 1, 1, 0, 0, 0, 0, 0, '0);
   endtask

   initial begin
      for (int i = 0; i < DD; i++) m_mem[i] = '0;

      // Reset held two cycles with push requested.
      step("rst0", 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_0001);
      step("rst1", 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_0002);
      chk("rst_cnt",  64'(ckpt_cnt_o), 64'd0);
      chk("rst_vld",  64'(ras_data_vld_o), 64'd0);
      chk("rst_data", 64'(ras_data_o), 64'd0);
      chk("rst_ovf",  64'(ras_ovf_o), 64'd0);

      // LIFO order.
      push("lifo_pA", 32'hA);
      push("lifo_pB", 32'hB);
      push("lifo_pC", 32'hC);
      push("lifo_pD", 32'hD);
      chk("lifo_full", 64'(ras_full_o), 64'd1);
      chk("lifo_top",  64'(ras_data_o), 64'hD);
      pop("lifo_pop1"); chk("lifo_C", 64'(ras_data_o), 64'hC);
      pop("lifo_pop2"); chk("lifo_B", 64'(ras_data_o), 64'hB);
      pop("lifo_pop3"); chk("lifo_A", 64'(ras_data_o), 64'hA);
      pop("lifo_pop4"); chk("lifo_empty", 64'(ras_data_vld_o), 64'd0);
      pop("lifo_pop5");
      chk("lifo_under_cnt", 64'(ckpt_cnt_o), 64'd0);
      chk("lifo_under_ptr", 64'(ckpt_ptr_o), 64'd0);

      // Overflow: five pushes into a four-entry stack.
      for (int i = 1; i <= 5; i++) push($sformatf("ovf_p%0d", i), DW'(i));
      chk("ovf_flag", 64'(ras_ovf_o), 64'd1);
      chk("ovf_cnt",  64'(ckpt_cnt_o), 64'd4);
      chk("ovf_top",  64'(ras_data_o), 64'd5);
      pop("ovf_pop1"); chk("ovf_4", 64'(ras_data_o), 64'd4);
      pop("ovf_pop2"); chk("ovf_3", 64'(ras_data_o), 64'd3);
      pop("ovf_pop3"); chk("ovf_2", 64'(ras_data_o), 64'd2);
      pop("ovf_pop4"); chk("ovf_empty", 64'(ras_data_vld_o), 64'd0);
      chk("ovf_sticky", 64'(ras_ovf_o), 64'd1);
      flush("ovf_flush");
      chk("ovf_cleared", 64'(ras_ovf_o), 64'd0);

      // Simultaneous push and pop.
      push("pp_pA", 32'hA);
      push("pp_pB", 32'hB);
      step("pp_X", 1, 0, 0, 0, 0, 1, 1, 32'h5858);
      chk("pp_X_top", 64'(ras_data_o), 64'h5858);
      chk("pp_X_cnt", 64'(ckpt_cnt_o), 64'd2);
      pop("pp_pop"); chk("pp_A", 64'(ras_data_o), 64'hA);
      pop("pp_pop2");
      step("pp_Y", 1, 0, 0, 0, 0, 1, 1, 32'h5959);
      chk("pp_Y_cnt", 64'(ckpt_cnt_o), 64'd1);
      chk("pp_Y_top", 64'(ras_data_o), 64'h5959);

      // Checkpoint and restore.
      flush("rs_flush");
      push("rs_pA", 32'hA);
      push("rs_pB", 32'hB);
      chk("rs_ckpt_ptr", 64'(ckpt_ptr_o), 64'd2);
      chk("rs_ckpt_cnt", 64'(ckpt_cnt_o), 64'd2);
      push("rs_pC", 32'hC);
      pop("rs_pop1");
      pop("rs_pop2");
      pop("rs_pop3");
      step("rs_restore", 1, 0, 1, 2, 2, 0, 0, '0);
      chk("rs_top", 64'(ras_data_o), 64'hB);
      chk("rs_cnt", 64'(ckpt_cnt_o), 64'd2);
      step("rs_restore_push", 1, 0, 1, 2, 2, 1, 0, 32'hEEEE);
      chk("rs_push_drop_top", 64'(ras_data_o), 64'hB);
      chk("rs_push_drop_cnt", 64'(ckpt_cnt_o), 64'd2);
      step("rs_clamp", 1, 0, 1, 2, 7, 0, 0, '0);
      chk("rs_clamp_cnt",  64'(ckpt_cnt_o), 64'd4);
      chk("rs_clamp_full", 64'(ras_full_o), 64'd1);

      // Flush beats a push into a full, overflowed stack.
      for (int i = 0; i < 5; i++) push($sformatf("fl_p%0d", i), DW'(32'h100 + i));
      step("fl_flush_push", 1, 1, 0, 0, 0, 1, 0, 32'hFFFF);
      chk("fl_cnt", 64'(ckpt_cnt_o), 64'd0);
      chk("fl_vld", 64'(ras_data_vld_o), 64'd0);
      chk("fl_ovf", 64'(ras_ovf_o), 64'd0);
      chk("fl_ptr", 64'(ckpt_ptr_o), 64'd0);

      // Reset mid-sequence with other requests active.
      push("mr_p1", 32'h77);
      push("mr_p2", 32'h78);
      step("mr_rst", 0, 1, 1, 3, 3, 1, 1, 32'h79);
      chk("mr_cnt", 64'(ckpt_cnt_o), 64'd0);
      chk("mr_ptr", 64'(ckpt_ptr_o), 64'd0);
      push("mr_after", 32'h80);
      chk("mr_after_top", 64'(ras_data_o), 64'h80);

      if (exp_q.size() != 0) chk("queue_drain", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spec_ras.md
SPEC_RAS -- requirements
Module: spec_ras

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, return-address width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL derive local parameters PTR_W = $clog2(DATA_DEPTH) and CNT_W = $clog2(DATA_DEPTH+1).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_i  in  1  clock, all state on rising edge; rst_ni  in  1  reset, synchronous, active-low.
REQ-005 SHALL have bp_flush_i  in  1  clear stack to empty.
REQ-006 SHALL have ras_push_i  in  1  push ras_data_i (call).
REQ-007 SHALL have ras_pop_i  in  1  pop top entry (return).
REQ-008 SHALL have ras_data_i  in  DATA_WIDTH  address to push.
REQ-009 SHALL have restore_i  in  1  restore pointer/count from checkpoint.
REQ-010 SHALL have restore_ptr_i  in  PTR_W  checkpointed top-of-stack pointer.
REQ-011 SHALL have restore_cnt_i  in  CNT_W  checkpointed occupancy.
REQ-012 SHALL have ckpt_ptr_o  out  PTR_W  current top-of-stack pointer.
REQ-013 SHALL have ckpt_cnt_o  out  CNT_W  current occupancy.
REQ-014 SHALL have ras_data_vld_o  out  1  stack non-empty.
REQ-015 SHALL have ras_data_o  out  DATA_WIDTH  top entry; 0 when empty.
REQ-016 SHALL have ras_full_o  out  1  occupancy == DATA_DEPTH.
REQ-017 SHALL have ras_ovf_o  out  1  sticky: an entry was overwritten.

Function
REQ-018 SHALL store entries in a circular buffer mem[DATA_DEPTH] with top pointer tos_q (PTR_W) and count cnt_q (0..DATA_DEPTH).
REQ-019 SHALL derive all outputs from registered state only; no combinational input-to-output path; any update is visible the cycle after the triggering edge.
REQ-020 SHALL apply per-cycle priority: reset > bp_flush_i > restore_i > push/pop; lower-priority requests in the same cycle are dropped.
REQ-021 SHALL on push only: tos_q <= tos_q+1 mod DATA_DEPTH; mem[tos_q+1] <= ras_data_i; cnt_q <= min(cnt_q+1, DATA_DEPTH).
REQ-022 SHALL on push when cnt_q == DATA_DEPTH overwrite the oldest entry, keep cnt_q = DATA_DEPTH, set ras_ovf_o.
REQ-023 SHALL on pop only with cnt_q > 0: tos_q <= tos_q-1 mod DATA_DEPTH; cnt_q <= cnt_q-1; mem unchanged.
REQ-024 SHALL on pop only with cnt_q == 0 leave all state unchanged (underflow ignored).
REQ-025 SHALL on simultaneous push and pop with cnt_q > 0: mem[tos_q] <= ras_data_i; tos_q, cnt_q unchanged.
REQ-026 SHALL on simultaneous push and pop with cnt_q == 0 behave as push only.
REQ-027 SHALL on restore_i: tos_q <= restore_ptr_i; cnt_q <= min(restore_cnt_i, DATA_DEPTH); mem and ras_ovf_o unchanged.
REQ-028 SHALL on bp_flush_i: tos_q <= 0; cnt_q <= 0; ras_ovf_o <= 0; mem unchanged.
REQ-029 SHALL drive ras_data_vld_o = (cnt_q != 0), ras_full_o = (cnt_q == DATA_DEPTH), ras_data_o = vld ? mem[tos_q] : 0, ckpt_ptr_o = tos_q, ckpt_cnt_o = cnt_q.
REQ-030 SHALL keep ras_ovf_o set until bp_flush_i or reset.

Reset
REQ-031 SHALL while rst_ni low at a rising edge set tos_q = 0, cnt_q = 0, ras_ovf_o = 0; mem is not reset.
REQ-032 SHALL after reset present ras_data_vld_o = 0, ras_full_o = 0, ras_data_o = 0, ckpt_ptr_o = 0, ckpt_cnt_o = 0.
REQ-033 SHALL ignore push/pop/restore/flush in any cycle where rst_ni is low, including mid-sequence.

Verification (DATA_DEPTH = 4)
REQ-034 SHALL cover reset: rst_ni low 2 cycles with ras_push_i = 1 -> cnt 0, vld 0, data_o 0, ovf 0.
REQ-035 SHALL cover LIFO order: push A,B,C,D -> full 1, data_o D; 4 pops -> data_o C,B,A, then vld 0; 5th pop -> no change.
REQ-036 SHALL cover overflow: push 1..5 -> ovf 1, cnt 4, data_o 5; pops -> 4,3,2, then empty; ovf remains 1 until flush.
REQ-037 SHALL cover push+pop: stack A,B, push+pop X -> data_o X, cnt 2; next pop -> data_o A; push+pop Y on empty -> cnt 1, data_o Y.
REQ-038 SHALL cover restore: push A,B, record ckpt (ptr 2, cnt 2); push C, pop x3; restore -> data_o B, cnt 2; restore with push in same cycle -> push dropped.
REQ-039 SHALL cover flush: stack full with push asserted and bp_flush_i = 1 -> next cycle cnt 0, vld 0, ovf 0, push dropped.
